// File: rtl/cache_maint_seq.sv
// Cache-wide flush/invalidate sequencer walking every set and way.
// Optional CACHE_MAINT_SKIP_EN: skip sets whose sampled work mask is empty.
module cache_maint_seq #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               FlushReq,
  input  logic               InvalidateReq,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WriteBackAck,
  output logic [SETLEN-1:0]  MaintAdr,
  output logic [NUMWAYS-1:0] MaintWay,
  output logic               WriteBackReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               CacheBusy,
  output logic               MaintDone
);

  localparam int WW = $clog2(NUMWAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SAMPLE,
    S_WAY,
    S_WB,
    S_NEXT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SETLEN-1:0]  set_q, set_d;
  logic [WW-1:0]      way_q, way_d;
  logic               dowb_q, dowb_d;
  logic               doinv_q, doinv_d;
  logic [NUMWAYS-1:0] dirty_q, dirty_d;
  logic               adv;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      dowb_q  <= 1'b0;
      doinv_q <= 1'b0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      dowb_q  <= dowb_d;
      doinv_q <= doinv_d;
      dirty_q <= dirty_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    way_d        = way_q;
    dowb_d       = dowb_q;
    doinv_d      = doinv_q;
    dirty_d      = dirty_q;
    adv          = 1'b0;
    MaintAdr     = '0;
    MaintWay     = '0;
    WriteBackReq = 1'b0;
    ClearDirty   = 1'b0;
    ClearValid   = 1'b0;
    CacheBusy    = (state_q != S_IDLE);
    MaintDone    = 1'b0;

    if (state_q != S_IDLE)
      MaintAdr = set_q;
    if (state_q == S_WAY || state_q == S_WB)
      MaintWay = NUMWAYS'(1) << way_q;

    unique case (state_q)
      S_IDLE: begin
        if (FlushReq || InvalidateReq) begin
          dowb_d  = FlushReq;
          doinv_d = InvalidateReq;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_SAMPLE;
      S_SAMPLE: begin
        dirty_d = DirtyWay & ValidWay;
        way_d   = '0;
        state_d = S_WAY;
`ifdef CACHE_MAINT_SKIP_EN
        if (((dowb_q ? (DirtyWay & ValidWay) : '0) |
             (doinv_q ? ValidWay : '0)) == '0)
          state_d = S_NEXT;
`endif
      end
      S_WAY: begin
        if (dowb_q && dirty_q[way_q]) begin
          state_d = S_WB;
        end else begin
          ClearValid = doinv_q;
          adv        = 1'b1;
        end
      end
      S_WB: begin
        WriteBackReq = 1'b1;
        if (WriteBackAck) begin
          ClearDirty = 1'b1;
          ClearValid = doinv_q;
          adv        = 1'b1;
        end
      end
      S_NEXT: begin
        if (set_q == SETLEN'(NUMLINES - 1)) begin
          set_d   = '0;
          state_d = S_DONE;
        end else begin
          set_d   = set_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        MaintDone = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (way_q == WW'(NUMWAYS - 1)) begin
        state_d = S_NEXT;
      end else begin
        way_d   = way_q + 1'b1;
        state_d = S_WAY;
      end
    end
  end

endmodule

// File: tb/tb_cache_maint_seq.sv
// Directed bench for cache_maint_seq with a 4-set, 4-way array model
// and a writeback engine acking in the third request cycle.
module tb_cache_maint_seq;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       FlushReq = 1'b0;
  logic       InvalidateReq = 1'b0;
  logic [3:0] ValidWay = '0;
  logic [3:0] DirtyWay = '0;
  logic       WriteBackAck = 1'b0;
  logic [8:0] MaintAdr;
  logic [3:0] MaintWay;
  logic       WriteBackReq;
  logic       ClearDirty;
  logic       ClearValid;
  logic       CacheBusy;
  logic       MaintDone;

  cache_maint_seq #(
    .NUMWAYS (4),
    .SETLEN  (9),
    .NUMLINES(4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .FlushReq     (FlushReq),
    .InvalidateReq(InvalidateReq),
    .ValidWay     (ValidWay),
    .DirtyWay     (DirtyWay),
    .WriteBackAck (WriteBackAck),
    .MaintAdr     (MaintAdr),
    .MaintWay     (MaintWay),
    .WriteBackReq (WriteBackReq),
    .ClearDirty   (ClearDirty),
    .ClearValid   (ClearValid),
    .CacheBusy    (CacheBusy),
    .MaintDone    (MaintDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0] varr [4];
  logic [3:0] darr [4];
  logic [3:0] rd_v, rd_d;
  int n_cv, n_cd, n_wb, n_bad, done_cnt, done_cyc, cnum, reqcnt;
  int first_adr;
  logic [8:0] wb_adr [$];
  logic [3:0] wb_way [$];
  logic       prev_req = 1'b0;
  logic [8:0] prev_adr = '0;
  logic [3:0] prev_way = '0;

  task automatic clr_stats();
    n_cv = 0; n_cd = 0; n_wb = 0; n_bad = 0;
    done_cnt = 0; done_cyc = 0; first_adr = -1;
    wb_adr.delete();
    wb_way.delete();
  endtask

  task automatic load(input logic [3:0] v, input logic [15:0] d);
    for (int s = 0; s < 4; s++) begin
      varr[s] = v;
      darr[s] = d[s*4 +: 4];
    end
  endtask

  function automatic logic [15:0] vall();
    return {varr[3], varr[2], varr[1], varr[0]};
  endfunction

  function automatic logic [15:0] dall();
    return {darr[3], darr[2], darr[1], darr[0]};
  endfunction

  function automatic logic [31:0] outs();
    return {14'd0, WriteBackReq, ClearDirty, ClearValid, CacheBusy,
            MaintDone, MaintAdr, MaintWay};
  endfunction

  // array model with registered read, plus monitor and writeback engine
  initial begin
    cnum = 0;
    reqcnt = 0;
    clr_stats();
    load(4'h0, 16'h0);
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (ClearValid) n_cv++;
        if (ClearDirty) n_cd++;
        if (WriteBackReq && !prev_req) begin
          n_wb++;
          wb_adr.push_back(MaintAdr);
          wb_way.push_back(MaintWay);
        end
        if (WriteBackReq && prev_req &&
            (MaintAdr != prev_adr || MaintWay != prev_way)) n_bad++;
        if (MaintDone) begin
          done_cnt++;
          done_cyc = cnum;
        end
        if (cnum == 1) first_adr = int'(MaintAdr);
        for (int w = 0; w < 4; w++) begin
          if (MaintWay[w] && MaintAdr < 9'd4) begin
            if (ClearValid) varr[MaintAdr[1:0]][w] = 1'b0;
            if (ClearDirty) darr[MaintAdr[1:0]][w] = 1'b0;
          end
        end
      end
      prev_req = WriteBackReq;
      prev_adr = MaintAdr;
      prev_way = MaintWay;
      cnum++;
      rd_v = (MaintAdr < 9'd4) ? varr[MaintAdr[1:0]] : 4'h0;
      rd_d = (MaintAdr < 9'd4) ? darr[MaintAdr[1:0]] : 4'h0;
      @(posedge clk);
      #1;
      ValidWay = rd_v;
      DirtyWay = rd_d;
      if (WriteBackReq) reqcnt++;
      else reqcnt = 0;
      WriteBackAck = (reqcnt == 3);
    end
  end

  task automatic start(input logic f, input logic inv);
    @(posedge clk);
    #1;
    FlushReq = f;
    InvalidateReq = inv;
    @(posedge clk);
    cnum = 1;
    #1;
    FlushReq = 1'b0;
    InvalidateReq = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int lim);
    int k;
    k = 0;
    while (done_cnt == 0 && k < lim) begin
      @(negedge clk);
      #2;
      k++;
    end
    check({tag, "_finished"}, 32'(done_cnt != 0), 32'd1);
  endtask

  function automatic logic [31:0] qa(input int i);
    return (wb_adr.size() > i) ? 32'(wb_adr[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qw(input int i);
    return (wb_way.size() > i) ? 32'(wb_way[i]) : 32'hDEAD;
  endfunction

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'd0);
    resetn = 1'b1;

    // 1: invalidate, all valid, none dirty
    load(4'hF, 16'h0000);
    clr_stats();
    start(1'b0, 1'b1);
    run_until_done("t1", 200);
    check("t1_clrvalid", n_cv, 16);
    check("t1_wb", n_wb, 0);
    check("t1_clrdirty", n_cd, 0);
    check("t1_done_cyc", done_cyc, 29);
    check("t1_valid_arr", 32'(vall()), 32'h0);

    // 2: flush, set 2 way 1 dirty
    load(4'hF, 16'h0200);
    clr_stats();
    start(1'b1, 1'b0);
    run_until_done("t2", 200);
    check("t2_wb", n_wb, 1);
    check("t2_wb_adr", qa(0), 32'd2);
    check("t2_wb_way", qw(0), 32'h2);
    check("t2_held", n_bad, 0);
    check("t2_clrdirty", n_cd, 1);
    check("t2_clrvalid", n_cv, 0);
    check("t2_done_cyc", done_cyc, 32);
    check("t2_dirty_arr", 32'(dall()), 32'h0);
    check("t2_valid_arr", 32'(vall()), 32'hFFFF);

    // 3: flush + invalidate, set 0 ways 0 and 3 dirty
    load(4'hF, 16'h0009);
    clr_stats();
    start(1'b1, 1'b1);
    run_until_done("t3", 200);
    check("t3_wb", n_wb, 2);
    check("t3_wb0_way", qw(0), 32'h1);
    check("t3_wb1_way", qw(1), 32'h8);
    check("t3_wb1_adr", qa(1), 32'd0);
    check("t3_clrvalid", n_cv, 16);
    check("t3_clrdirty", n_cd, 2);
    check("t3_done_cyc", done_cyc, 35);
    check("t3_arrays", {vall(), dall()}, 32'h0);

    // 4: reset while a writeback is pending
    load(4'hF, 16'h0020);
    clr_stats();
    start(1'b1, 1'b0);
    k = 0;
    while (!WriteBackReq && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("t4_reached_wb", 32'(WriteBackReq), 32'd1);
    resetn = 1'b0;
    #1;
    check("t4_async_outs", outs(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check("t4_no_done", done_cnt, 0);
    check("t4_dirty_kept", 32'(dall()), 32'h0020);
    clr_stats();
    start(1'b1, 1'b0);
    run_until_done("t4", 200);
    check("t4_first_adr", first_adr, 0);
    check("t4_wb_adr", qa(0), 32'd1);
    check("t4_wb_way", qw(0), 32'h2);
    check("t4_done_cyc", done_cyc, 32);

    // 5: request while busy is ignored
    load(4'hF, 16'h0000);
    clr_stats();
    start(1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t5_busy", 32'(CacheBusy), 32'd1);
    FlushReq = 1'b1;
    @(posedge clk);
    #1;
    FlushReq = 1'b0;
    run_until_done("t5", 200);
    repeat (40) @(posedge clk);
    #1;
    check("t5_done_cnt", done_cnt, 1);
    check("t5_done_cyc", done_cyc, 29);
    check("t5_idle", 32'(CacheBusy), 32'd0);

`ifdef CACHE_MAINT_SKIP_EN
    // 6: skip empty sets
    load(4'hF, 16'h0000);
    clr_stats();
    start(1'b1, 1'b0);
    run_until_done("t6a", 200);
    check("t6a_done_cyc", done_cyc, 13);
    check("t6a_clears", n_cd + n_cv, 0);
    load(4'hF, 16'h0200);
    clr_stats();
    start(1'b1, 1'b0);
    run_until_done("t6b", 200);
    check("t6b_wb", n_wb, 1);
    check("t6b_done_cyc", done_cyc, 20);
    check("t6b_dirty_arr", 32'(dall()), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
